// File: rtl/control_seq_if.sv
// Memory-side bus of the fetch/decode/execute sequencer: address plus read/write request
// and a single ready handshake shared by instruction fetch and data access.
interface control_seq_if #(
  parameter int PC_W = 8
);
  logic [PC_W-1:0] pc;
  logic            mem_rd;
  logic            mem_wr;
  logic            mem_ready;

  modport master (
    output pc,
    output mem_rd,
    output mem_wr,
    input  mem_ready
  );

  modport slave (
    input  pc,
    input  mem_rd,
    input  mem_wr,
    output mem_ready
  );
endinterface

// File: rtl/control_seq.sv
// Multi-cycle fetch/decode/execute sequencer owning the PC and driving datapath controls.
// Optional retired-instruction counter enabled by defining CTRL_ICOUNT_EN.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for run
// FETCH  | reading instruction word at pc; IL on mem_ready
// DECODE | instruction register outputs settle
// EXEC   | per-opcode controls; LD/ST hold here until mem_ready
// HALT   | frozen until reset
module control_seq #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk_main,
  input  logic                 reset,
  control_seq_if.master        mem,
  input  logic                 run,
  input  logic [3:0]           opcode,
  input  logic [3:0]           SA,
  input  logic [3:0]           SB,
  input  logic                 zero,
  output logic                 IL,
  output logic                 RW,
  output logic [3:0]           FS,
  output logic                 MB,
  output logic                 MD,
  output logic                 halted,
  output logic [2:0]           state_dbg,
  output logic [15:0]          icount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_NOT  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_LDI  = 4'h8;
  localparam logic [3:0] OP_LD   = 4'h9;
  localparam logic [3:0] OP_ST   = 4'hA;
  localparam logic [3:0] OP_BRZ  = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [3:0]      FS_SUB  = 4'h2;
  localparam logic [3:0]      FS_PASS = 4'h7;
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  state_t          state;
  logic [PC_W-1:0] pc_q;
  logic            mem_rd_c;
  logic            mem_wr_c;
  logic            exec_done;
  logic            take_branch;
  logic            retire;
  logic [PC_W-1:0] branch_target;

  // {SA,SB} is an 8-bit absolute target, resized to the PC width
  assign branch_target = PC_W'({SA, SB});
  assign retire        = (state == S_EXEC) && exec_done;

  always_ff @(posedge clk_main) begin
    if (reset) begin
      state <= S_IDLE;
      pc_q  <= RESET_PC;
    end else begin
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem.mem_ready) begin
            pc_q  <= pc_q + PC_ONE;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (take_branch) pc_q <= branch_target;
          if (exec_done) state <= (opcode == OP_HALT) ? S_HALT : S_FETCH;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    IL          = 1'b0;
    RW          = 1'b0;
    FS          = 4'h0;
    MB          = 1'b0;
    MD          = 1'b0;
    mem_rd_c    = 1'b0;
    mem_wr_c    = 1'b0;
    exec_done   = 1'b0;
    take_branch = 1'b0;
    case (state)
      S_FETCH: begin
        mem_rd_c = 1'b1;
        IL       = mem.mem_ready;
      end
      S_EXEC: begin
        exec_done = 1'b1;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOT: begin
            RW = 1'b1;
            FS = opcode;
          end
          OP_MOV: begin
            RW = 1'b1;
            FS = FS_PASS;
          end
          OP_LDI: begin
            RW = 1'b1;
            MB = 1'b1;
            FS = FS_PASS;
          end
          OP_LD: begin
            // write-back only on the cycle the read data is actually valid
            mem_rd_c  = 1'b1;
            MD        = 1'b1;
            RW        = mem.mem_ready;
            exec_done = mem.mem_ready;
          end
          OP_ST: begin
            mem_wr_c  = 1'b1;
            exec_done = mem.mem_ready;
          end
          OP_BRZ: begin
            FS          = FS_SUB;
            take_branch = zero;
          end
          OP_JMP: begin
            take_branch = 1'b1;
          end
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  assign mem.pc     = pc_q;
  assign mem.mem_rd = mem_rd_c;
  assign mem.mem_wr = mem_wr_c;
  assign halted     = (state == S_HALT);
  assign state_dbg  = state;

`ifdef CTRL_ICOUNT_EN
  logic [15:0] icount_q;

  always_ff @(posedge clk_main) begin
    if (reset) begin
      icount_q <= 16'h0000;
    end else if (retire) begin
      icount_q <= icount_q + 16'd1;
    end
  end

  assign icount = icount_q;
`else
  assign icount = 16'h0000;
`endif

endmodule

// File: tb/tb_control_seq.sv
// Bench for control_seq: directed scenarios with literal expectations plus randomized
// programs and memory handshakes checked every cycle against an instruction-level model.
module tb_control_seq;
  localparam int         PC_W     = 8;
  localparam logic [7:0] RESET_PC = 8'h00;

  logic        clk_main  = 1'b0;
  logic        reset     = 1'b1;
  logic        run       = 1'b0;
  logic        zero      = 1'b0;
  logic        mem_ready = 1'b0;
  logic [3:0]  opcode    = 4'h0;
  logic [3:0]  SA        = 4'h0;
  logic [3:0]  SB        = 4'h0;
  logic        IL, RW, MB, MD, halted;
  logic [3:0]  FS;
  logic [2:0]  state_dbg;
  logic [15:0] icount;

  control_seq_if #(.PC_W(PC_W)) mem ();
  assign mem.mem_ready = mem_ready;

  control_seq #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .mem       (mem),
    .run       (run),
    .opcode    (opcode),
    .SA        (SA),
    .SB        (SB),
    .zero      (zero),
    .IL        (IL),
    .RW        (RW),
    .FS        (FS),
    .MB        (MB),
    .MD        (MD),
    .halted    (halted),
    .state_dbg (state_dbg),
    .icount    (icount)
  );

  always #5 clk_main = ~clk_main;

  int checks = 0;
  int fails  = 0;
  logic [11:0] prog [256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      if (fails <= 30) $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Instruction semantics as a lookup: what each opcode drives during execute.
  typedef struct {
    bit       rw;
    bit [3:0] fs;
    bit       mb;
    bit       md;
    int       mem_kind;   // 0 none, 1 read, 2 write
  } op_t;

  function automatic op_t op_info(input logic [3:0] op);
    op_t r;
    r.rw = 1'b0; r.fs = 4'h0; r.mb = 1'b0; r.md = 1'b0; r.mem_kind = 0;
    if (op >= 4'h1 && op <= 4'h6) begin r.rw = 1'b1; r.fs = op; end
    else if (op == 4'h7) begin r.rw = 1'b1; r.fs = 4'h7; end
    else if (op == 4'h8) begin r.rw = 1'b1; r.fs = 4'h7; r.mb = 1'b1; end
    else if (op == 4'h9) begin r.md = 1'b1; r.mem_kind = 1; end
    else if (op == 4'hA) begin r.mem_kind = 2; end
    else if (op == 4'hB) begin r.fs = 4'h2; end
    return r;
  endfunction

  localparam logic [2:0] PH_IDLE = 3'd0, PH_FETCH = 3'd1, PH_DECODE = 3'd2,
                         PH_EXEC = 3'd3, PH_HALT = 3'd4;
  bit          m_valid = 1'b0;
  logic [2:0]  m_ph    = PH_IDLE;
  logic [7:0]  m_pc    = RESET_PC;
  logic [15:0] m_ic    = 16'h0000;

  // Reference model also plays the instruction register: it loads prog[pc] on a fetch.
  always @(negedge clk_main) begin : model
    op_t        oi;
    logic       e_il, e_rd, e_wr, e_rw, e_mb, e_md;
    logic [3:0] e_fs;
    logic [2:0] n_ph;
    logic [7:0] n_pc;
    bit         ret;
    if (reset) begin
      m_ph = PH_IDLE; m_pc = RESET_PC; m_ic = 16'h0000; m_valid = 1'b1;
    end else if (m_valid) begin
      e_il = 0; e_rd = 0; e_wr = 0; e_rw = 0; e_mb = 0; e_md = 0; e_fs = 4'h0;
      n_ph = m_ph; n_pc = m_pc; ret = 1'b0;
      oi = op_info(opcode);
      if (m_ph == PH_IDLE) begin
        if (run) n_ph = PH_FETCH;
      end else if (m_ph == PH_FETCH) begin
        e_rd = 1'b1;
        if (mem_ready) begin e_il = 1'b1; n_pc = m_pc + 8'd1; n_ph = PH_DECODE; end
      end else if (m_ph == PH_DECODE) begin
        n_ph = PH_EXEC;
      end else if (m_ph == PH_EXEC) begin
        e_rw = oi.rw; e_fs = oi.fs; e_mb = oi.mb; e_md = oi.md;
        if (oi.mem_kind == 1) begin e_rd = 1'b1; e_rw = mem_ready; end
        if (oi.mem_kind == 2) e_wr = 1'b1;
        ret = (oi.mem_kind == 0) || mem_ready;
        if (opcode == 4'hC || (opcode == 4'hB && zero)) n_pc = {SA, SB};
        if (ret) n_ph = (opcode == 4'hF) ? PH_HALT : PH_FETCH;
      end
      chk("m_state",  32'(state_dbg), 32'(m_ph));
      chk("m_pc",     32'(mem.pc),    32'(m_pc));
      chk("m_IL",     32'(IL),        32'(e_il));
      chk("m_mem_rd", 32'(mem.mem_rd), 32'(e_rd));
      chk("m_mem_wr", 32'(mem.mem_wr), 32'(e_wr));
      chk("m_RW",     32'(RW),        32'(e_rw));
      chk("m_FS",     32'(FS),        32'(e_fs));
      chk("m_MB",     32'(MB),        32'(e_mb));
      chk("m_MD",     32'(MD),        32'(e_md));
      chk("m_halted", 32'(halted),    32'(m_ph == PH_HALT));
`ifdef CTRL_ICOUNT_EN
      chk("m_icount", 32'(icount),    32'(m_ic));
`else
      chk("m_icount", 32'(icount),    32'h0);
`endif
      if (e_il) {opcode, SA, SB} = prog[m_pc];
      if (ret) m_ic = m_ic + 16'd1;
      m_ph = n_ph;
      m_pc = n_pc;
    end
  end

  // Inputs change just after the rising edge; checks happen on the following falling edge.
  task automatic step(input logic r_st, input logic r_run, input logic rdy, input logic z);
    @(posedge clk_main);
    #1;
    reset = r_st; run = r_run; mem_ready = rdy; zero = z;
    @(negedge clk_main);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 12'h000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog at %0t: got timeout expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: ADD fetch/decode/execute timing
    clear_prog();
    prog[0] = 12'h112;
    do_reset();
    chk("t1_rst_state", 32'(state_dbg), 0);
    chk("t1_rst_pc",    32'(mem.pc),    0);
    chk("t1_rst_halt",  32'(halted),    0);
    chk("t1_rst_icnt",  32'(icount),    0);
    step(0, 1, 1, 0);
    chk("t1_idle", 32'(state_dbg), 0);
    step(0, 0, 1, 0);
    chk("t1_f_state", 32'(state_dbg), 1);
    chk("t1_f_IL",    32'(IL), 1);
    chk("t1_f_pc",    32'(mem.pc), 0);
    step(0, 0, 1, 0);
    chk("t1_d_state", 32'(state_dbg), 2);
    chk("t1_d_pc",    32'(mem.pc), 1);
    step(0, 0, 1, 0);
    chk("t1_e_RW", 32'(RW), 1);
    chk("t1_e_FS", 32'(FS), 1);
    step(0, 0, 1, 0);
    chk("t1_f2_state", 32'(state_dbg), 1);
    chk("t1_f2_RW",    32'(RW), 0);
`ifdef CTRL_ICOUNT_EN
    chk("t1_icount", 32'(icount), 1);
`endif

    // 2 + 5: LDI, stalled ST, stalled LD, then HALT
    clear_prog();
    prog[0] = 12'h805; prog[1] = 12'hA00; prog[2] = 12'h900; prog[3] = 12'hF00;
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t2_ldi_RW", 32'(RW), 1);
    chk("t2_ldi_MB", 32'(MB), 1);
    chk("t2_ldi_FS", 32'(FS), 7);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t2_st_wait_wr",    32'(mem.mem_wr), 1);
      chk("t2_st_wait_state", 32'(state_dbg), 3);
    end
    step(0, 0, 1, 0);
    chk("t2_st_ack_wr", 32'(mem.mem_wr), 1);
    chk("t2_st_ack_RW", 32'(RW), 0);
    step(0, 0, 1, 0);
    chk("t2_st_rel_wr", 32'(mem.mem_wr), 0);
    chk("t2_st_rel_st", 32'(state_dbg), 1);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      chk("t2_ld_wait_RW", 32'(RW), 0);
      chk("t2_ld_wait_rd", 32'(mem.mem_rd), 1);
    end
    step(0, 0, 1, 0);
    chk("t2_ld_ack_RW", 32'(RW), 1);
    chk("t2_ld_ack_MD", 32'(MD), 1);
    step(0, 0, 1, 0);
    chk("t2_ld_done_RW", 32'(RW), 0);
    chk("t2_ld_done_MD", 32'(MD), 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t5_halted", 32'(halted), 1);
    chk("t5_state",  32'(state_dbg), 4);
    chk("t5_pc",     32'(mem.pc), 4);
`ifdef CTRL_ICOUNT_EN
    chk("t5_icount", 32'(icount), 4);
`endif
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0);
      step(0, 0, 1, 0);
    end
    chk("t5_still_halt", 32'(halted), 1);
    chk("t5_pc_frozen",  32'(mem.pc), 4);
    do_reset();
    chk("t5_rst_state", 32'(state_dbg), 0);
    chk("t5_rst_pc",    32'(mem.pc), 0);
    chk("t5_rst_halt",  32'(halted), 0);

    // 3: BRZ taken, BRZ not taken, JMP 00
    clear_prog();
    prog[8'h00] = 12'hB42; prog[8'h42] = 12'hB42; prog[8'h43] = 12'hC00;
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    chk("t3_brz_FS", 32'(FS), 2);
    step(0, 0, 1, 0);
    chk("t3_taken_pc", 32'(mem.pc), 32'h42);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t3_nt_pc", 32'(mem.pc), 32'h43);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t3_jmp_pc", 32'(mem.pc), 32'h00);

    // 4: pc wrap FF -> 00 on a NOP fetch
    clear_prog();
    prog[8'h00] = 12'hCFF;
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    chk("t4_fetch_pc", 32'(mem.pc), 32'hFF);
    step(0, 0, 1, 0);
    chk("t4_wrap_pc", 32'(mem.pc), 32'h00);
    step(0, 0, 1, 0);
    chk("t4_nop_strobes", 32'({IL, mem.mem_rd, mem.mem_wr, RW, MB, MD, FS}), 0);

    // 6: reset during a stalled ST
    clear_prog();
    prog[0] = 12'hA00;
    do_reset();
    step(0, 1, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    chk("t6_stall_wr", 32'(mem.mem_wr), 1);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("t6_after_wr",    32'(mem.mem_wr), 0);
    chk("t6_after_state", 32'(state_dbg), 0);
    chk("t6_after_icnt",  32'(icount), 0);
    step(0, 0, 1, 0);
    chk("t6_later_wr", 32'(mem.mem_wr), 0);

    // randomized programs and handshakes, checked by the model every cycle
    for (int ep = 0; ep < 8; ep++) begin
      for (int i = 0; i < 256; i++) begin
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (op == 4'hF && $urandom_range(0, 7) != 0) op = 4'h0;
        prog[i] = {op, 8'($urandom_range(0, 255))};
      end
      do_reset();
      for (int c = 0; c < 400; c++) begin
        step(($urandom_range(0, 249) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 9) < 6),
             1'($urandom_range(0, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
